// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the stopwatch controller.
// Holds the FSM encoding, the BCD time bundle and its increment helper.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_e;

    localparam logic [3:0] DIGIT_MAX9 = 4'd9;
    localparam logic [3:0] DIGIT_MAX5 = 4'd5;

    typedef struct packed {
        logic [3:0] min;
        logic [3:0] sec_tens;
        logic [3:0] sec_ones;
        logic [3:0] tenths;
    } bcd_time_t;

    localparam bcd_time_t TIME_ZERO = '0;
    localparam bcd_time_t TIME_MAX  = '{
        min:      DIGIT_MAX9,
        sec_tens: DIGIT_MAX5,
        sec_ones: DIGIT_MAX9,
        tenths:   DIGIT_MAX9
    };

    // Advance a BCD time by one tenth, wrapping 9:59.9 back to 0:00.0.
    function automatic bcd_time_t bcd_inc(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.tenths != DIGIT_MAX9) begin
            r.tenths = t.tenths + 4'd1;
        end else begin
            r.tenths = 4'd0;
            if (t.sec_ones != DIGIT_MAX9) begin
                r.sec_ones = t.sec_ones + 4'd1;
            end else begin
                r.sec_ones = 4'd0;
                if (t.sec_tens != DIGIT_MAX5) begin
                    r.sec_tens = t.sec_tens + 4'd1;
                end else begin
                    r.sec_tens = 4'd0;
                    if (t.min != DIGIT_MAX9) begin
                        r.min = t.min + 4'd1;
                    end else begin
                        r.min = 4'd0;
                    end
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_tick_gen.sv
// Tenth-second prescaler: counts 0..TICK_DIV-1 while enabled.
// Holds its value when disabled; tick marks the last count.
module tick_gen #(
    parameter int TICK_DIV = 5_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: advance when enabled, roll over after the last count.
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
        end
    end

    assign tick = en && (cnt_q == LAST);

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: command FSM, live BCD chain, lap snapshot.
// Display shows the snapshot in LAP and the live time otherwise.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 5_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clear,
    output logic [3:0] disp_min,
    output logic [3:0] disp_sec_tens,
    output logic [3:0] disp_sec_ones,
    output logic [3:0] disp_tenths,
    output logic       running,
    output logic       lap_active,
    output logic       overflow
);

    state_e    state_q;
    state_e    state_d;
    bcd_time_t live_q;
    bcd_time_t live_d;
    bcd_time_t snap_q;
    bcd_time_t snap_d;
    bcd_time_t disp;
    logic      ovf_q;
    logic      ovf_d;
    logic      do_clear;
    logic      snap_load;
    logic      tick;
    logic      tg_en;
    logic      tg_reset;

    assign tg_en    = (state_q == RUN) || (state_q == LAP);
    assign tg_reset = reset && !do_clear;

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .reset(tg_reset),
        .en   (tg_en),
        .tick (tick)
    );

    // Next state: one command per cycle, start_stop > lap > clear.
    always_comb begin
        state_d   = state_q;
        do_clear  = 1'b0;
        snap_load = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_stop) state_d = RUN;
            end
            RUN: begin
                if (start_stop) begin
                    state_d = PAUSE;
                end else if (lap) begin
                    state_d   = LAP;
                    snap_load = 1'b1;
                end
            end
            LAP: begin
                if (start_stop) begin
                    state_d = PAUSE;
                end else if (lap) begin
                    state_d = RUN;
                end
            end
            PAUSE: begin
                if (start_stop) begin
                    state_d = RUN;
                end else if (clear && !lap) begin
                    state_d  = IDLE;
                    do_clear = 1'b1;
                end
            end
        endcase
    end

    // Time datapath: clear, tick increment and pre-increment snapshot.
    always_comb begin
        live_d = live_q;
        snap_d = snap_q;
        ovf_d  = 1'b0;
        if (do_clear) begin
            live_d = TIME_ZERO;
            snap_d = TIME_ZERO;
        end else begin
            if (tick) begin
                live_d = bcd_inc(live_q);
                ovf_d  = (live_q == TIME_MAX);
            end
            if (snap_load) begin
                snap_d = live_q;
            end
        end
    end

    // State and time registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            live_q  <= TIME_ZERO;
            snap_q  <= TIME_ZERO;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= live_d;
            snap_q  <= snap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign disp          = (state_q == LAP) ? snap_q : live_q;
    assign disp_min      = disp.min;
    assign disp_sec_tens = disp.sec_tens;
    assign disp_sec_ones = disp.sec_ones;
    assign disp_tenths   = disp.tenths;
    assign running       = tg_en;
    assign lap_active    = (state_q == LAP);
    assign overflow      = ovf_q;

endmodule
